// File: rtl/stack_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stack_mem_pkg
//  Purpose  : Command opcodes and FSM state encodings for stack_mem_ctrl.
//  Revision : 1.0
// ============================================================================
package stack_mem_pkg;

   localparam int OP_W    = 3;
   localparam int STATE_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 3'd0,
      OP_PUSH  = 3'd1,
      OP_POP   = 3'd2,
      OP_POP2  = 3'd3,
      OP_PEEK  = 3'd4,
      OP_LOAD  = 3'd5,
      OP_STORE = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_ACC1 = 2'd1,
      ST_ACC2 = 2'd2,
      ST_RESP = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/stack_ptr_unit.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ptr_unit
//  Purpose  : Saturating stack entry counter with full/empty/lt2 flags and sp.
//  Revision : 1.0
// ============================================================================
module stack_ptr_unit #(
   parameter int ABITS       = 32,
   parameter int STACK_BASE  = 768,
   parameter int STACK_DEPTH = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             dec2_i,
   output logic             full_o,
   output logic             empty_o,
   output logic             lt2_o,
   output logic [ABITS-1:0] sp_o
);

   localparam int               CBITS   = $clog2(STACK_DEPTH + 1);
   localparam logic [CBITS-1:0] C_DEPTH = CBITS'(STACK_DEPTH);

   logic [CBITS-1:0] count_q;
   logic [CBITS-1:0] count_d;

   assign full_o  = (count_q == C_DEPTH);
   assign empty_o = (count_q == '0);
   assign lt2_o   = (count_q < CBITS'(2));
   assign sp_o    = ABITS'(STACK_BASE) + ABITS'(count_q);

   // Never wraps: requests that would cross either bound are ignored.
   always_comb begin
      count_d = count_q;
      if (inc_i && !full_o) begin
         count_d = count_q + CBITS'(1);
      end else if (dec2_i && !lt2_o) begin
         count_d = count_q - CBITS'(2);
      end else if (dec_i && !empty_o) begin
         count_d = count_q - CBITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stack_mem_ctrl
//  Purpose  : Stack/load/store command engine driving the data_mem port.
//  Revision : 1.0
// ============================================================================
module stack_mem_ctrl
   import stack_mem_pkg::*;
#(
   parameter int DBITS       = 32,
   parameter int ABITS       = 32,
   parameter int STACK_BASE  = 768,
   parameter int STACK_DEPTH = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [DBITS-1:0] cmd_data,
   input  logic [ABITS-1:0] cmd_addr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DBITS-1:0] rsp_data,
   output logic [DBITS-1:0] rsp_data2,
   output logic             rsp_err,
   output logic             err_ovf,
   output logic             err_udf,
   output logic [ABITS-1:0] sp,
   output logic             mem_en,
   output logic             mem_we,
   output logic [ABITS-1:0] mem_addr,
   output logic [DBITS-1:0] mem_din,
   input  logic [DBITS-1:0] mem_dout
);

   state_e           state_q;
   op_e              op_q;
   logic             en_q;
   logic             we_q;
   logic [ABITS-1:0] addr_q;
   logic [DBITS-1:0] din_q;
   logic [DBITS-1:0] rdata_q;
   logic [DBITS-1:0] rdata2_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic             ovf_q;
   logic             udf_q;

   logic             full;
   logic             empty;
   logic             lt2;
   logic             ptr_inc;
   logic             ptr_dec;
   logic             accept;
   op_e              new_op;
   logic             new_mem;
   logic             new_we;
   logic             new_ovf;
   logic             new_udf;
   logic [ABITS-1:0] new_addr;

   assign new_op    = op_e'(cmd_op);
   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Decode of the offered command, evaluated against the current stack fill.
   always_comb begin
      new_mem  = 1'b0;
      new_we   = 1'b0;
      new_ovf  = 1'b0;
      new_udf  = 1'b0;
      new_addr = cmd_addr;
      case (new_op)
         OP_PUSH: begin
            new_mem  = 1'b1;
            new_we   = 1'b1;
            new_ovf  = full;
            new_addr = sp;
         end
         OP_POP, OP_PEEK: begin
            new_mem  = 1'b1;
            new_udf  = empty;
            new_addr = sp - ABITS'(1);
         end
         OP_POP2: begin
            new_mem  = 1'b1;
            new_udf  = lt2;
            new_addr = sp - ABITS'(1);
         end
         OP_LOAD: begin
            new_mem  = 1'b1;
         end
         OP_STORE: begin
            new_mem  = 1'b1;
            new_we   = 1'b1;
         end
         default: begin
            new_mem  = 1'b0;
         end
      endcase
   end

   assign ptr_inc = (state_q == ST_ACC1) && (op_q == OP_PUSH);
   assign ptr_dec = ((state_q == ST_ACC1) && ((op_q == OP_POP) || (op_q == OP_POP2)))
                 || (state_q == ST_ACC2);

   stack_ptr_unit #(
      .ABITS       (ABITS),
      .STACK_BASE  (STACK_BASE),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ptr (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (ptr_inc),
      .dec_i   (ptr_dec),
      .dec2_i  (1'b0),
      .full_o  (full),
      .empty_o (empty),
      .lt2_o   (lt2),
      .sp_o    (sp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         en_q        <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         rdata_q     <= '0;
         rdata2_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept && new_mem) begin
                  op_q     <= new_op;
                  rdata_q  <= '0;
                  rdata2_q <= '0;
                  if (new_ovf || new_udf) begin
                     ovf_q       <= ovf_q | new_ovf;
                     udf_q       <= udf_q | new_udf;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     rsp_err_q <= 1'b0;
                     en_q      <= 1'b1;
                     we_q      <= new_we;
                     addr_q    <= new_addr;
                     din_q     <= new_we ? cmd_data : '0;
                     state_q   <= ST_ACC1;
                  end
               end
            end
            ST_ACC1: begin
               if (!we_q) begin
                  rdata_q <= mem_dout;
               end
               we_q <= 1'b0;
               // Second POP2 read sits one below the first (old sp-2).
               if (op_q == OP_POP2) begin
                  addr_q  <= addr_q - ABITS'(1);
                  state_q <= ST_ACC2;
               end else begin
                  en_q        <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_ACC2: begin
               rdata2_q    <= mem_dout;
               en_q        <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data  = rdata_q;
   assign rsp_data2 = rdata2_q;
   assign err_ovf   = ovf_q;
   assign err_udf   = udf_q;
   assign mem_en    = en_q;
   // Gating with rst keeps an interrupted write from landing.
   assign mem_we    = we_q & ~rst;
   assign mem_addr  = addr_q;
   assign mem_din   = din_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_stack_mem_ctrl
//  Purpose  : Randomized self-checking bench for stack_mem_ctrl with a memory.
//  Revision : 1.0
// ============================================================================
module tb_stack_mem_ctrl;

   localparam int BASE  = 768;
   localparam int DEPTH = 256;
   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, POP2 = 3'd3,
                          PEEK = 3'd4, LOAD = 3'd5, STORE = 3'd6, RSVD = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [31:0] cmd_data = '0;
   logic [31:0] cmd_addr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data, rsp_data2;
   logic        rsp_err, err_ovf, err_udf;
   logic [31:0] sp;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_din, mem_dout;

   int err_cnt = 0;
   int chk_cnt = 0;
   int en_cycles = 0;

   logic [31:0] mem [0:2047] = '{default: 32'h0};
   logic [31:0] ref_mem [0:2047];
   int          ref_cnt;
   logic        ref_ovf, ref_udf;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[10:0]] <= mem_din;
   end
   assign mem_dout = mem_en ? mem[mem_addr[10:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_en) en_cycles <= en_cycles + 1;
   end

   stack_mem_ctrl #(
      .DBITS(32), .ABITS(32), .STACK_BASE(BASE), .STACK_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_addr(cmd_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
      .err_ovf(err_ovf), .err_udf(err_udf), .sp(sp),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      ref_cnt = 0; ref_ovf = 1'b0; ref_udf = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_sp", sp, BASE);
      chk("rst_flags", {err_ovf, err_udf, rsp_err}, 0);
      chk("rst_mem_ctl", {mem_en, mem_we}, 0);
      chk("rst_data", {rsp_data, rsp_data2}, 0);
      chk("rst_mem_bus", {mem_addr, mem_din}, 0);
   endtask

   // Applies one command, predicts its outcome from the stack rules and checks the response.
   task automatic issue(input logic [2:0] op, input logic [31:0] d,
                        input logic [31:0] a, input int hold);
      logic        exp_err;
      logic [31:0] e1, e2;
      int          exp_acc, lat, en0;
      exp_err = 1'b0; e1 = '0; e2 = '0; exp_acc = 0;
      case (op)
         PUSH:  if (ref_cnt == DEPTH) begin exp_err = 1'b1; ref_ovf = 1'b1; end
                else begin ref_mem[BASE + ref_cnt] = d; ref_cnt++; exp_acc = 1; end
         POP:   if (ref_cnt == 0) begin exp_err = 1'b1; ref_udf = 1'b1; end
                else begin ref_cnt--; e1 = ref_mem[BASE + ref_cnt]; exp_acc = 1; end
         POP2:  if (ref_cnt < 2) begin exp_err = 1'b1; ref_udf = 1'b1; end
                else begin
                   e1 = ref_mem[BASE + ref_cnt - 1];
                   e2 = ref_mem[BASE + ref_cnt - 2];
                   ref_cnt -= 2; exp_acc = 2;
                end
         PEEK:  if (ref_cnt == 0) begin exp_err = 1'b1; ref_udf = 1'b1; end
                else begin e1 = ref_mem[BASE + ref_cnt - 1]; exp_acc = 1; end
         LOAD:  begin e1 = ref_mem[a[10:0]]; exp_acc = 1; end
         STORE: begin ref_mem[a[10:0]] = d; exp_acc = 1; end
         default: ;
      endcase

      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_addr = a;
      en0 = en_cycles;
      @(posedge clk);
      #1 cmd_valid = 1'b0; cmd_op = NOP;

      if (op == NOP || op == RSVD) begin
         repeat (2) @(posedge clk);
         #1;
         chk("nop_no_rsp", rsp_valid, 0);
         chk("nop_ready", cmd_ready, 1);
         chk("nop_no_mem", en_cycles - en0, 0);
         return;
      end

      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("latency", lat, exp_err ? 1 : exp_acc + 1);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_data", rsp_data, e1);
      chk("rsp_data2", rsp_data2, e2);
      chk("err_ovf", err_ovf, ref_ovf);
      chk("err_udf", err_udf, ref_udf);
      chk("mem_cycles", en_cycles - en0, exp_acc);
      chk("ready_in_resp", cmd_ready, 0);
      chk("sp", sp, BASE + ref_cnt);

      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("rsp_held", {rsp_valid, rsp_data}, {1'b1, e1});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("rsp_dropped", rsp_valid, 0);
      chk("ready_back", cmd_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] last_val, t6_old;
      int bad;
      for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
      ref_cnt = 0; ref_ovf = 1'b0; ref_udf = 1'b0;

      // Basic push/pop
      do_reset();
      issue(PUSH, 32'hA, 0, 0);
      issue(PUSH, 32'hB, 0, 1);
      issue(POP, 0, 0, 0);
      chk("t1_mem768", mem[768], 32'hA);

      // POP2 ordering and three-cycle latency
      do_reset();
      issue(PUSH, 32'd1, 0, 0);
      issue(PUSH, 32'd2, 0, 0);
      issue(PUSH, 32'd3, 0, 0);
      issue(POP2, 0, 0, 2);

      // Fill to the brim then overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         last_val = $urandom;
         issue(PUSH, last_val, 0, 0);
      end
      issue(PUSH, 32'hFF, 0, 0);
      chk("t3_sp_full", sp, 1024);
      chk("t3_mem1023", mem[1023], last_val);

      // Underflow from empty and with a single entry
      do_reset();
      issue(POP, 0, 0, 0);
      issue(PUSH, 32'd5, 0, 0);
      issue(POP2, 0, 0, 0);

      // Direct access and peek
      issue(STORE, 32'h1234, 32'd10, 0);
      issue(LOAD, 0, 32'd10, 0);
      issue(PUSH, 32'd7, 0, 0);
      issue(PEEK, 0, 0, 1);
      issue(NOP, 0, 0, 0);
      issue(RSVD, 0, 0, 0);

      // Reset during the write cycle of a PUSH
      do_reset();
      t6_old = ref_mem[BASE];
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = ~t6_old;
      @(posedge clk);
      #1 cmd_valid = 1'b0; cmd_op = NOP;
      chk("t6_we_before_rst", mem_we, 1);
      rst = 1'b1;
      #1;
      chk("t6_we_gated", mem_we, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      ref_cnt = 0; ref_ovf = 1'b0; ref_udf = 1'b0;
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_sp", sp, BASE);
      chk("t6_mem_target", mem[BASE], t6_old);

      // Randomized command mix
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         if (ref_cnt < 4 && $urandom_range(0, 1) == 0) op = PUSH;
         issue(op, $urandom, 32'($urandom_range(0, 1100)), $urandom_range(0, 2));
      end

      bad = 0;
      for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("mem_image", bad, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
